// File: rtl/e_tile_operand_buffer_pkg.sv
// Shared types for the E-tile operand buffer: slot encodings,
// operand/instruction types and the per-entry bookkeeping record.
package e_tile_operand_buffer_pkg;

    localparam int ETILE_ENTRIES = 8;
    localparam int REG_DATA_W    = 64;

    typedef logic [6:0]            instr_num_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    typedef enum logic [1:0] {
        SLOT_LEFT  = 2'd0,
        SLOT_RIGHT = 2'd1,
        SLOT_PRED  = 2'd2,
        SLOT_RSVD  = 2'd3
    } slot_e;

    typedef struct packed {
        logic       mapped;
        logic       issued;
        logic [2:0] needs;
        logic [2:0] have;
    } entry_t;

    function automatic logic entry_ready(entry_t e);
        return e.mapped & ~e.issued & ((e.have & e.needs) == e.needs);
    endfunction

endpackage

// File: rtl/opbuf_prio_sel.sv
// Lowest-index priority encoder over a request vector,
// returning the winning index and an any-set flag.
module opbuf_prio_sel #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/e_tile_operand_buffer.sv
// E-tile reservation-station operand buffer: captures operands, issues
// one ready entry per cycle. OPBUF_BYPASS_EN adds same-cycle presentation.
module e_tile_operand_buffer
    import e_tile_operand_buffer_pkg::*;
#(
    parameter int NUM_SLOTS = ETILE_ENTRIES,
    parameter int DATA_W    = REG_DATA_W,
    parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              map_we,
    input  logic [IDX_W-1:0]  map_idx,
    input  logic [2:0]        map_needs,
    input  logic              op_req,
    output logic              op_ack,
    input  logic [6:0]        op_dest_instr,
    input  logic [1:0]        op_dest_slot,
    input  logic [DATA_W-1:0] op_data,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [IDX_W-1:0]  iss_idx,
    output logic [DATA_W-1:0] iss_left,
    output logic [DATA_W-1:0] iss_right,
    output logic              iss_pred,
    output logic              dup_err
);

    entry_t                ent_q [NUM_SLOTS];
    entry_t                ent_d [NUM_SLOTS];
    logic [DATA_W-1:0]     lval_q [NUM_SLOTS];
    logic [DATA_W-1:0]     rval_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  pval_q;

    logic                  valid_q, pred_q, dup_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_W-1:0]     left_q, right_q;

    logic                  pv, pp;
    logic [IDX_W-1:0]      pidx;
    logic [DATA_W-1:0]     pl, pr;

    logic [IDX_W-1:0]      dst;
    logic                  unused_instr;
    logic                  acc, dup, cap, map_dst, fire, hold, drop;
    logic [3:0]            have_ext;
    logic [2:0]            slot_oh;

    logic [NUM_SLOTS-1:0]  rdy_d;
    logic [IDX_W-1:0]      sel_d;
    logic                  any_d, hit_d;
    logic [DATA_W-1:0]     nl, nr;
    logic                  np;

    // Upper instruction bits only matter for tile steering upstream.
    assign dst          = op_dest_instr[IDX_W-1:0];
    assign unused_instr = ^op_dest_instr;

    assign acc      = op_req & ~flush & ~rst;
    assign op_ack   = acc;
    assign map_dst  = map_we & (map_idx == dst);
    // A same-cycle map clears have first, so it never counts as a repeat.
    assign have_ext = {1'b1, map_dst ? 3'b000 : ent_q[dst].have};
    assign dup      = acc & have_ext[op_dest_slot];
    assign cap      = acc & ~dup;
    assign slot_oh  = 3'(4'b0001 << op_dest_slot);

    assign fire = pv & iss_ready & ~flush;
    assign hold = pv & ~iss_ready;
    assign drop = pv & map_we & (map_idx == pidx);

    // Next entry state: fire, then map clear, then capture; flush wins.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            ent_d[i] = ent_q[i];
            if (fire && pidx == IDX_W'(i)) begin
                ent_d[i].issued = 1'b1;
            end
            if (map_we && map_idx == IDX_W'(i)) begin
                ent_d[i].mapped = 1'b1;
                ent_d[i].needs  = map_needs;
                ent_d[i].have   = 3'b000;
                ent_d[i].issued = 1'b0;
            end
            if (cap && dst == IDX_W'(i)) begin
                ent_d[i].have = ent_d[i].have | slot_oh;
            end
            if (flush) begin
                ent_d[i].mapped = 1'b0;
                ent_d[i].have   = 3'b000;
                ent_d[i].issued = 1'b0;
            end
            rdy_d[i] = entry_ready(ent_d[i]);
        end
    end

    opbuf_prio_sel #(.N(NUM_SLOTS), .W(IDX_W)) u_sel_d (
        .req (rdy_d),
        .idx (sel_d),
        .any (any_d)
    );

    // Operand values of the next winner, forwarding this cycle's capture.
    always_comb begin
        hit_d = cap & (dst == sel_d);
        nl = (hit_d & slot_oh[SLOT_LEFT])  ? op_data : lval_q[sel_d];
        nr = (hit_d & slot_oh[SLOT_RIGHT]) ? op_data : rval_q[sel_d];
        np = (hit_d & slot_oh[SLOT_PRED])  ? op_data[0] : pval_q[sel_d];
        if (!ent_d[sel_d].needs[2]) begin
            np = 1'b1;
        end
    end

`ifdef OPBUF_BYPASS_EN
    entry_t               cmp_e;
    logic                 byp_hit, hit_b, any_b;
    logic [NUM_SLOTS-1:0] rdy_b;
    logic [IDX_W-1:0]     sel_b;

    // Detect a delivery that completes an entry while nothing is shown.
    always_comb begin
        cmp_e      = ent_q[dst];
        cmp_e.have = cmp_e.have | slot_oh;
        byp_hit    = cap & ~valid_q & ~map_dst & entry_ready(cmp_e);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            rdy_b[i] = entry_ready(ent_q[i]) |
                       (byp_hit & (dst == IDX_W'(i)));
        end
    end

    opbuf_prio_sel #(.N(NUM_SLOTS), .W(IDX_W)) u_sel_b (
        .req (rdy_b),
        .idx (sel_b),
        .any (any_b)
    );

    // Presented view: registered state, or the bypassed winner.
    always_comb begin
        pv    = valid_q;
        pidx  = idx_q;
        pl    = left_q;
        pr    = right_q;
        pp    = pred_q;
        hit_b = cap & (dst == sel_b);
        if (byp_hit & any_b) begin
            pv   = 1'b1;
            pidx = sel_b;
            pl   = (hit_b & slot_oh[SLOT_LEFT])  ? op_data : lval_q[sel_b];
            pr   = (hit_b & slot_oh[SLOT_RIGHT]) ? op_data : rval_q[sel_b];
            pp   = (hit_b & slot_oh[SLOT_PRED])  ? op_data[0] : pval_q[sel_b];
            if (!ent_q[sel_b].needs[2]) begin
                pp = 1'b1;
            end
        end
    end
`else
    // Presented view is purely the registered issue state.
    always_comb begin
        pv   = valid_q;
        pidx = idx_q;
        pl   = left_q;
        pr   = right_q;
        pp   = pred_q;
    end
`endif

    assign iss_valid = pv;
    assign iss_idx   = pidx;
    assign iss_left  = pl;
    assign iss_right = pr;
    assign iss_pred  = pp;
    assign dup_err   = dup_q;

    // Entry bookkeeping and operand storage.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (rst) begin
                ent_q[i]  <= '0;
                lval_q[i] <= '0;
                rval_q[i] <= '0;
                pval_q[i] <= 1'b0;
            end else begin
                ent_q[i] <= ent_d[i];
                if (cap && dst == IDX_W'(i)) begin
                    if (slot_oh[SLOT_LEFT])  lval_q[i] <= op_data;
                    if (slot_oh[SLOT_RIGHT]) rval_q[i] <= op_data;
                    if (slot_oh[SLOT_PRED])  pval_q[i] <= op_data[0];
                end
            end
        end
    end

    // Issue register: hold while stalled, else present the next winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            left_q  <= '0;
            right_q <= '0;
            pred_q  <= 1'b0;
            dup_q   <= 1'b0;
        end else begin
            dup_q <= dup;
            if (flush || drop) begin
                valid_q <= 1'b0;
            end else if (hold) begin
                valid_q <= 1'b1;
                idx_q   <= pidx;
                left_q  <= pl;
                right_q <= pr;
                pred_q  <= pp;
            end else begin
                valid_q <= any_d;
                idx_q   <= sel_d;
                left_q  <= nl;
                right_q <= nr;
                pred_q  <= np;
            end
        end
    end

endmodule

// File: doc/e_tile_operand_buffer.md
Name: e_tile_operand_buffer

Overview:
- Per-E-tile reservation-station operand buffer.
- Sits directly downstream of the operand network and acts as the receiver side of operand_if, taking operand deliveries addressed by dest_instr/dest_slot.
- Captures left, right and predicate operands for each locally mapped instruction, tracks readiness, and issues one ready instruction per cycle to the E-tile ALU through a valid/ready handshake.
- Flushed by the G-tile on block commit or abort.

Parameters:
- NUM_SLOTS, 8, instruction entries per E-tile (128-instruction block / 16 E-tiles); power of 2.
- DATA_W, 64, operand data width (matches reg_data_t).
- IDX_W, $clog2(NUM_SLOTS), local entry index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  clear all entries (block commit/abort)
- map_we  in  1  load entry config
- map_idx  in  IDX_W  entry being configured
- map_needs  in  3  required operands {pred,right,left}
- op_req  in  1  operand delivery request (operand_if.req)
- op_ack  out  1  operand accepted (operand_if.ack)
- op_dest_instr  in  7  destination instruction number
- op_dest_slot  in  2  0=left, 1=right, 2=pred, 3=reserved
- op_data  in  DATA_W  operand value
- iss_valid  out  1  ready instruction presented
- iss_ready  in  1  ALU accepts
- iss_idx  out  IDX_W  issued entry index
- iss_left  out  DATA_W  left operand
- iss_right  out  DATA_W  right operand
- iss_pred  out  1  predicate value (bit 0 of pred operand; 1 if pred not needed)
- dup_err  out  1  one-cycle pulse on duplicate or reserved-slot delivery

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset: all entries invalid, needs=0, issued=0. op_ack=0, iss_valid=0, iss_idx=0, iss_left=0, iss_right=0, iss_pred=0, dup_err=0. Reset mid-delivery drops the operand with no ack.
- Entry state: needs[2:0], have[2:0], issued, mapped, lval, rval, pval.
- Entry index: local index = op_dest_instr[IDX_W-1:0]. Upper bits are ignored; tile steering is done upstream.
- Accept: op_ack = op_req & ~flush & ~rst, combinational. The sender drops req the cycle after ack.
- Capture: on an accepted delivery the operand is written at the clock edge and have[slot] is set.
- Duplicate or reserved delivery: if have[slot] is already 1, or slot==3, the data is discarded, op_ack is still asserted, and dup_err pulses the next cycle.
- Ready condition: mapped & ~issued & ((have & needs) == needs). needs==0 means ready immediately after mapping.
- Selection: lowest-index ready entry. Outputs are registered, so iss_* reflects state from the previous edge (1-cycle latency from the last operand arrival to iss_valid).
- Issue hold: while iss_valid & ~iss_ready, iss_idx and the data stay stable; no reselection happens.
- Issue fire: on iss_valid & iss_ready, the entry's issued bit is set and the next ready entry may be presented the following cycle. Back-to-back issue is one per cycle.
- Map: map_we sets needs, sets mapped=1, clears have and issued for map_idx.
- Map and delivery to the same entry in the same cycle: the clear is applied first, then the operand is captured.
- Map on the presented entry: iss_valid drops the next cycle.
- Flush: priority over everything; clears mapped/have/issued for all entries and iss_valid the next cycle. An iss_ready coinciding with flush is ignored.
- Error pulse: dup_err is a registered one-cycle pulse.

Optional Feature:
- Macro: OPBUF_BYPASS_EN.
- Defined: when no entry is currently presented and an accepted delivery completes an entry, that entry is presented combinationally in the same cycle (0-cycle latency). The operand is forwarded from op_data, and lowest-index priority still applies among ready entries.
- Undefined: 1-cycle registered latency as above.

Decomposition:
- Shared trips package: operand slot encodings (SLOT_LEFT=0, SLOT_RIGHT=1, SLOT_PRED=2), instr_num_t, reg_data_t, E-tile entry count constant.
- One natural sub-module: opbuf_prio_sel, a parameterised lowest-index priority encoder over the ready vector, outputting index and any-valid.

Test Plan:
- Map entry 3 needs=3'b011; deliver left=0x11 then right=0x22 (dest_instr=3) -> iss_valid one cycle after the right-operand ack, iss_idx=3, left=0x11, right=0x22, iss_pred=1.
- Entries 2 and 5 both ready in the same cycle, iss_ready held 0 for 3 cycles -> idx 2 held stable; after the fire, idx 5 is presented the next cycle.
- Map entry 1 needs=3'b100; deliver pred data=0 -> issue with iss_pred=0. Deliver pred again to entry 1 -> op_ack=1, dup_err pulses, no reissue.
- Delivery with slot=3 -> ack, dup_err pulse, have unchanged.
- Entry 4 presented and stalled; assert flush with iss_ready=1 -> iss_valid=0 next cycle, no fire counted; a subsequent delivery to entry 4 does not issue until it is remapped.
- With OPBUF_BYPASS_EN: map entry 0 needs=3'b001, deliver left=0xAB -> iss_valid=1, iss_left=0xAB in the same cycle as op_ack.
